// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - octave encodings, note period table and ms tick helpers for tone_poly_synth
package tone_pkg;

    localparam logic [1:0] OCT_MID     = 2'b00;
    localparam logic [1:0] OCT_LOW     = 2'b01;
    localparam logic [1:0] OCT_HIGH    = 2'b10;
    localparam logic [1:0] OCT_ILLEGAL = 2'b11;

    // Middle-octave frequencies in Hz x100; index 7 is C of the next octave up.
    function automatic longint unsigned note_freq_x100(input logic [2:0] note);
        case (note)
            3'd0:    return 64'd26163;
            3'd1:    return 64'd29366;
            3'd2:    return 64'd32963;
            3'd3:    return 64'd34923;
            3'd4:    return 64'd39200;
            3'd5:    return 64'd44000;
            3'd6:    return 64'd49388;
            default: return 64'd52325;
        endcase
    endfunction

    // Lower octave halves the x100 frequency before rounding so C low lands on 130.81 Hz.
    function automatic longint unsigned note_period(input logic [1:0] shift, input logic [2:0] note,
                                                    input longint unsigned clk_hz);
        longint unsigned f;
        f = note_freq_x100(note);
        case (shift)
            OCT_LOW:  f = f / 64'd2;
            OCT_HIGH: f = f * 64'd2;
            OCT_MID:  f = f;
            default:  return 64'd0;
        endcase
        return (clk_hz * 64'd100 + f / 64'd2) / f;
    endfunction

    function automatic int unsigned ms_ticks(input longint unsigned clk_hz);
        return 32'(clk_hz / 64'd1000);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// rtl/tone_channel.sv - one tone voice: period counter, ms timebase, duration countdown, square output
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          DIV_W  = 20,
    parameter int          DUR_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_kill,
    input  logic [DIV_W-1:0] i_period,
    input  logic [DUR_W-1:0] i_dur,
    output logic             o_active,
    output logic             o_done,
    output logic             o_square
);

    localparam int unsigned MS       = ms_ticks(64'(CLK_HZ));
    localparam int          MS_W     = (MS > 1) ? $clog2(MS) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS - 1);

    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] r_cnt;
    logic [MS_W-1:0]  r_ms;
    logic [DUR_W-1:0] r_dur;
    logic             r_active;
    logic             r_done;

    logic w_cnt_wrap;
    logic w_ms_wrap;

    assign w_cnt_wrap = (r_cnt == r_period - DIV_W'(1));
    assign w_ms_wrap  = (r_ms == MS_LAST);

    // A load in the same cycle as natural expiry takes priority, so no done is raised.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_ms     <= '0;
            r_dur    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_period <= i_period;
                r_cnt    <= '0;
                r_ms     <= '0;
                r_dur    <= i_dur;
                r_active <= 1'b1;
            end else if (i_kill) begin
                r_cnt    <= '0;
                r_ms     <= '0;
                r_dur    <= '0;
                r_active <= 1'b0;
            end else if (r_active) begin
                r_cnt <= w_cnt_wrap ? '0 : r_cnt + DIV_W'(1);
                r_ms  <= w_ms_wrap ? '0 : r_ms + MS_W'(1);
                if (w_ms_wrap && (r_dur != '0)) begin
                    r_dur <= r_dur - DUR_W'(1);
                    if (r_dur == DUR_W'(1)) begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_ms     <= '0;
                    end
                end
            end
        end
    end

    assign o_active = r_active;
    assign o_done   = r_done;
    assign o_square = r_active & (r_cnt < (r_period >> 1));

endmodule

// File: rtl/tone_poly_synth.sv
// rtl/tone_poly_synth.sv - command handshake, note decode, NUM_CH tone channels and sigma-delta mixer
module tone_poly_synth
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          NUM_CH = 4,
    parameter int          DIV_W  = 20,
    parameter int          DUR_W  = 16,
    localparam int         CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [CH_W-1:0]   i_cmd_ch,
    input  logic              i_cmd_stop,
    input  logic [1:0]        i_cmd_shift,
    input  logic [2:0]        i_cmd_note,
    input  logic [DUR_W-1:0]  i_cmd_dur,
    output logic [NUM_CH-1:0] o_ch_active,
    output logic [NUM_CH-1:0] o_ch_done,
    output logic              o_pwm
);

    localparam int ACC_W = $clog2(NUM_CH) + 1;

    logic             r_pend;
    logic [CH_W-1:0]  r_ch;
    logic             r_stop;
    logic [1:0]       r_shift;
    logic [2:0]       r_note;
    logic [DUR_W-1:0] r_dur;
    logic [ACC_W-1:0] r_acc;
    logic             r_pwm;

    logic             w_accept;
    logic             w_off;
    logic [DIV_W-1:0] w_period;
    logic [DIV_W-1:0] w_table [32];
    logic [NUM_CH-1:0] w_square;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W:0]   w_total;

    assign o_cmd_ready = ~i_rst & ~r_pend;
    assign w_accept    = i_cmd_valid & o_cmd_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= 1'b0;
            r_ch    <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_note  <= '0;
            r_dur   <= '0;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_ch    <= i_cmd_ch;
                r_stop  <= i_cmd_stop;
                r_shift <= i_cmd_shift;
                r_note  <= i_cmd_note;
                r_dur   <= i_cmd_dur;
            end
        end
    end

    // Periods are elaboration-time constants, so the lookup is a plain 32-entry ROM.
    for (genvar s = 0; s < 4; s++) begin : g_oct
        for (genvar n = 0; n < 8; n++) begin : g_note
            localparam longint unsigned P = note_period(2'(s), 3'(n), 64'(CLK_HZ));
            assign w_table[s*8+n] = P[DIV_W-1:0];
        end
    end

    assign w_period = w_table[{r_shift, r_note}];
    assign w_off    = r_stop | (r_shift == OCT_ILLEGAL);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_hit;
        assign w_hit = r_pend & (r_ch == CH_W'(g));

        tone_channel #(
            .CLK_HZ (CLK_HZ),
            .DIV_W  (DIV_W),
            .DUR_W  (DUR_W)
        ) u_channel (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_load   (w_hit & ~w_off),
            .i_kill   (w_hit & w_off),
            .i_period (w_period),
            .i_dur    (r_dur),
            .o_active (o_ch_active[g]),
            .o_done   (o_ch_done[g]),
            .o_square (w_square[g])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sum = w_sum + ACC_W'(w_square[k]);
        end
    end

    assign w_total = {1'b0, r_acc} + {1'b0, w_sum};

    // First-order sigma-delta: emit a 1 each time the accumulated level crosses NUM_CH.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_acc <= '0;
            r_pwm <= 1'b0;
        end else if (w_total >= (ACC_W+1)'(NUM_CH)) begin
            r_acc <= ACC_W'(w_total - (ACC_W+1)'(NUM_CH));
            r_pwm <= 1'b1;
        end else begin
            r_acc <= w_total[ACC_W-1:0];
            r_pwm <= 1'b0;
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: tb/tb_tone_poly_synth.sv
// tb/tb_tone_poly_synth.sv - directed bench for tone_poly_synth at a 1 MHz clock (1000 clks per ms)
module tb_tone_poly_synth;

    localparam int unsigned CLK_HZ = 1_000_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst, en;

    logic       v4, rdy4, stop4;
    logic [1:0] ch4, sh4;
    logic [2:0] note4;
    logic [15:0] dur4;
    logic [3:0] act4, done4;
    logic       pwm4;

    logic       v1, rdy1, stop1, ch1;
    logic [1:0] sh1;
    logic [2:0] note1;
    logic [15:0] dur1;
    logic       act1, done1, pwm1;

    tone_poly_synth #(.CLK_HZ(CLK_HZ), .NUM_CH(4), .DIV_W(20), .DUR_W(16)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_cmd_valid(v4), .o_cmd_ready(rdy4),
        .i_cmd_ch(ch4), .i_cmd_stop(stop4), .i_cmd_shift(sh4), .i_cmd_note(note4),
        .i_cmd_dur(dur4), .o_ch_active(act4), .o_ch_done(done4), .o_pwm(pwm4)
    );

    tone_poly_synth #(.CLK_HZ(CLK_HZ), .NUM_CH(1), .DIV_W(20), .DUR_W(16)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_cmd_valid(v1), .o_cmd_ready(rdy1),
        .i_cmd_ch(ch1), .i_cmd_stop(stop1), .i_cmd_shift(sh1), .i_cmd_note(note1),
        .i_cmd_dur(dur1), .o_ch_active(act1), .o_ch_done(done1), .o_pwm(pwm1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 20000 && cyc < target; i++) @(negedge clk);
    endtask

    // Call just after a negedge; returns just after the accept edge with e1 = index of the load edge.
    task automatic send4(input logic [1:0] ch, input logic stop, input logic [1:0] sh,
                         input logic [2:0] note, input logic [15:0] dur, output int e1);
        ch4 = ch; stop4 = stop; sh4 = sh; note4 = note; dur4 = dur; v4 = 1'b1;
        for (int i = 0; i < 8 && !rdy4; i++) @(negedge clk);
        check("ready4_before_send", int'(rdy4), 1);
        @(posedge clk);
        #1;
        v4 = 1'b0;
        e1 = cyc + 1;
    endtask

    task automatic send1(input logic [1:0] sh, input logic [2:0] note, input logic [15:0] dur,
                         output int e1);
        ch1 = 1'b0; stop1 = 1'b0; sh1 = sh; note1 = note; dur1 = dur; v1 = 1'b1;
        for (int i = 0; i < 8 && !rdy1; i++) @(negedge clk);
        check("ready1_before_send", int'(rdy1), 1);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        e1 = cyc + 1;
    endtask

    initial begin
        int e1, e1b, cnt, t, hi, lo;
        rst = 1'b1; en = 1'b1;
        v4 = 1'b0; ch4 = '0; stop4 = 1'b0; sh4 = '0; note4 = '0; dur4 = '0;
        v1 = 1'b0; ch1 = 1'b0; stop1 = 1'b0; sh1 = '0; note1 = '0; dur1 = '0;

        // Reset state and ready release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(rdy4), 0);
        check("rst_active", int'(act4), 0);
        check("rst_done", int'(done4), 0);
        check("rst_pwm", int'(pwm4), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", int'(rdy4), 1);

        // Reset mid-note with a command pending
        send4(2'd0, 1'b0, 2'b00, 3'd5, 16'd0, e1);
        wait_until(e1 + 20);
        check("sustain_active", int'(act4), 4'b0001);
        send4(2'd2, 1'b0, 2'b00, 3'd0, 16'd7, e1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_active", int'(act4), 0);
        check("midrst_pwm", int'(pwm4), 0);
        check("midrst_done", int'(done4), 0);
        check("midrst_ready", int'(rdy4), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", int'(rdy4), 1);
        repeat (5) @(negedge clk);
        check("pending_discarded", int'(act4), 0);

        // Timed note: done exactly 3 ms after load edge
        send4(2'd0, 1'b0, 2'b00, 3'd0, 16'd3, e1);
        wait_until(e1);
        check("t3_active_at_e1", int'(act4[0]), 1);
        wait_until(e1 + 2999);
        check("t3_active_before_expiry", int'(act4[0]), 1);
        check("t3_no_early_done", int'(done4[0]), 0);
        @(negedge clk);
        check("t3_done_at_3ms", int'(done4[0]), 1);
        check("t3_active_fell", int'(act4[0]), 0);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            cnt += int'(done4[0]);
        end
        check("t3_single_pulse", cnt, 0);

        // Retrigger at 2 ms preempts the 5 ms note
        send4(2'd0, 1'b0, 2'b00, 3'd0, 16'd5, e1);
        wait_until(e1 + 1998);
        send4(2'd0, 1'b0, 2'b00, 3'd2, 16'd1, e1b);
        cnt = 0; t = 0;
        for (int i = 0; i < 8000 && cyc < e1 + 6000; i++) begin
            @(negedge clk);
            if (done4[0]) begin
                cnt++;
                if (t == 0) t = cyc;
            end
        end
        check("retrig_done_count", cnt, 1);
        check("retrig_done_time", t - e1b, 1000);

        // Command landing on the expiry edge wins: no done, channel keeps sounding
        @(negedge clk);
        send4(2'd1, 1'b0, 2'b00, 3'd0, 16'd1, e1);
        wait_until(e1 + 998);
        send4(2'd1, 1'b0, 2'b00, 3'd4, 16'd0, e1b);
        cnt = 0;
        repeat (1500) begin
            @(negedge clk);
            cnt += int'(done4[1]);
        end
        check("collide_no_done", cnt, 0);
        check("collide_active", int'(act4), 4'b0010);

        // Stop command silences without done
        @(negedge clk);
        send4(2'd1, 1'b1, 2'b00, 3'd0, 16'd0, e1);
        wait_until(e1);
        check("stop_active", int'(act4), 0);
        check("stop_no_done", int'(done4), 0);

        // Two identical notes: density 2/4 during shared high phase
        @(negedge clk);
        send4(2'd0, 1'b0, 2'b00, 3'd5, 16'd0, e1);
        @(negedge clk);
        send4(2'd1, 1'b0, 2'b00, 3'd5, 16'd0, e1b);
        wait_until(e1b + 10);
        check("pair_active", int'(act4), 4'b0011);
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            cnt += int'(pwm4);
        end
        check("pair_density", cnt, 500);

        // Mute mid timed note: pwm forced low, done still on time
        @(negedge clk);
        send4(2'd2, 1'b0, 2'b00, 3'd0, 16'd2, e1);
        wait_until(e1 + 100);
        en = 1'b0;
        @(negedge clk);
        check("mute_pwm_next_edge", int'(pwm4), 0);
        cnt = 0;
        repeat (500) begin
            @(negedge clk);
            cnt += int'(pwm4);
        end
        check("mute_pwm_stays_low", cnt, 0);
        wait_until(e1 + 1999);
        check("mute_no_early_done", int'(done4), 0);
        @(negedge clk);
        check("mute_done_on_time", int'(done4), 4'b0100);
        check("mute_active_after", int'(act4), 4'b0011);
        en = 1'b1;

        // Illegal octave silences channel 0
        @(negedge clk);
        send4(2'd0, 1'b0, 2'b11, 3'd3, 16'd4, e1);
        wait_until(e1);
        check("illegal_active", int'(act4), 4'b0010);
        check("illegal_no_done", int'(done4), 0);

        // Single channel: A middle pwm waveform
        @(negedge clk);
        send1(2'b00, 3'd5, 16'd0, e1);
        wait_until(e1);
        check("one_active_at_e1", int'(act1), 1);
        check("one_pwm_at_e1", int'(pwm1), 0);
        @(negedge clk);
        check("one_pwm_at_e2", int'(pwm1), 1);
        hi = 0; lo = 0;
        for (int i = 0; i < 5000 && pwm1; i++) begin
            hi++;
            @(negedge clk);
        end
        for (int i = 0; i < 5000 && !pwm1; i++) begin
            lo++;
            @(negedge clk);
        end
        check("one_high_clks", hi, 1136);
        check("one_period_clks", hi + lo, 2273);
        check("one_no_done", int'(done1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
